// File: rtl/source_sequencer_pkg.sv
// source_seq_pkg: sequencer states, source mux channel codes and the channel advance search.
package source_seq_pkg;

    typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} state_e;

    localparam logic [1:0] CH_COUNTER   = 2'd0;
    localparam logic [1:0] CH_PRBS      = 2'd1;
    localparam logic [1:0] CH_CONST     = 2'd2;
    localparam logic [1:0] CH_CONST_BAR = 2'd3;

    // Walks sel+4 (itself) down to sel+1 so the nearest enabled successor is written last.
    function automatic logic [1:0] next_enabled(input logic [1:0] sel, input logic [3:0] mask);
        logic [1:0] r;
        logic [1:0] c;
        r = sel;
        for (int i = 4; i >= 1; i--) begin
            c = sel + 2'(i);
            if (mask[c]) r = c;
        end
        return r;
    endfunction

endpackage

// File: rtl/source_sequencer_if.sv
// source_sequencer_if: lock, button, mask inputs and channel select/qualifier outputs of the sequencer.
interface source_sequencer_if;
    logic       pll_locked;
    logic       btn_next;
    logic       btn_mode;
    logic [3:0] ch_mask;
    logic [1:0] sel;
    logic       src_valid;
    logic       auto_mode;
    logic       trigger;

    modport master (
        output pll_locked, btn_next, btn_mode, ch_mask,
        input  sel, src_valid, auto_mode, trigger
    );

    modport slave (
        input  pll_locked, btn_next, btn_mode, ch_mask,
        output sel, src_valid, auto_mode, trigger
    );
endinterface

// File: rtl/source_sequencer_btn_fall_detect.sv
// btn_fall_detect: registered 1->0 edge detector; history resets to 1 (idle-high button).
module btn_fall_detect (
    input  logic clk1280,
    input  logic FPGA_RESETn,
    input  logic btn_i,
    output logic fall_o
);
    logic hist_q;

    always_ff @(posedge clk1280 or negedge FPGA_RESETn) begin
        if (!FPGA_RESETn) hist_q <= 1'b1;
        else              hist_q <= btn_i;
    end

    assign fall_o = hist_q & ~btn_i;
endmodule

// File: rtl/source_sequencer.sv
// source_sequencer: lock/settle/run sequencing of the FMCA test-pattern channel select.
// SOURCE_SEQ_AUTO_EN adds auto-cycling with a dwell timer and the btn_mode toggle.
module source_sequencer
    import source_seq_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES  = 1280,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned TRIG_WIDTH    = 4
) (
    input  logic                clk1280,
    input  logic                FPGA_RESETn,
    source_sequencer_if.slave   bus
);
    localparam logic [31:0] SETTLE_LOAD = 32'(SETTLE_CYCLES - 1);
    localparam logic [31:0] TRIG_LOAD   = 32'(TRIG_WIDTH);

    state_e      state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic [31:0] settle_q, settle_d;
    logic [31:0] trig_q, trig_d;
    logic        next_fall;
    logic        expire;
    logic        auto_q;

    btn_fall_detect u_next (
        .clk1280     (clk1280),
        .FPGA_RESETn (FPGA_RESETn),
        .btn_i       (bus.btn_next),
        .fall_o      (next_fall)
    );

`ifdef SOURCE_SEQ_AUTO_EN
    logic        mode_fall;
    logic [31:0] dwell_q, dwell_d;

    btn_fall_detect u_mode (
        .clk1280     (clk1280),
        .FPGA_RESETn (FPGA_RESETn),
        .btn_i       (bus.btn_mode),
        .fall_o      (mode_fall)
    );

    // A mode edge restarts the dwell, so it also suppresses an expiry in the same cycle.
    assign expire = auto_q && !mode_fall && (dwell_q == 32'(DWELL_CYCLES - 1));

    always_comb begin
        dwell_d = (state_q != RUN || state_d != RUN || mode_fall || expire) ? '0 : dwell_q + 32'(auto_q);
    end

    always_ff @(posedge clk1280 or negedge FPGA_RESETn) begin
        if (!FPGA_RESETn) begin
            auto_q  <= 1'b0;
            dwell_q <= '0;
        end else begin
            auto_q  <= auto_q ^ mode_fall;
            dwell_q <= dwell_d;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = bus.btn_mode ^ (^32'(DWELL_CYCLES));
    assign expire     = 1'b0;
    assign auto_q     = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        settle_d = settle_q;
        trig_d   = '0;
        if (!bus.pll_locked) begin
            state_d  = WAIT_LOCK;
            settle_d = '0;
        end else if (state_q == WAIT_LOCK) begin
            state_d  = SETTLE;
            settle_d = SETTLE_LOAD;
        end else if (state_q == SETTLE) begin
            state_d  = (settle_q == '0) ? RUN : SETTLE;
            settle_d = settle_q - 32'(settle_q != '0);
            trig_d   = (settle_q == '0) ? TRIG_LOAD : '0;
        end else if ((next_fall || expire) && |bus.ch_mask) begin
            state_d  = SETTLE;
            sel_d    = next_enabled(sel_q, bus.ch_mask);
            settle_d = SETTLE_LOAD;
        end else begin
            trig_d = trig_q - 32'(trig_q != '0);
        end
    end

    always_ff @(posedge clk1280 or negedge FPGA_RESETn) begin
        if (!FPGA_RESETn) begin
            state_q  <= WAIT_LOCK;
            sel_q    <= CH_COUNTER;
            settle_q <= '0;
            trig_q   <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            settle_q <= settle_d;
            trig_q   <= trig_d;
        end
    end

    assign bus.sel       = sel_q;
    assign bus.src_valid = (state_q == RUN);
    assign bus.trigger   = |trig_q;
    assign bus.auto_mode = auto_q;
endmodule

// File: tb/tb_source_sequencer.sv
// tb_source_sequencer: random and directed stimulus against a timestamp-based model of the sequencer.
module tb_source_sequencer;
    localparam int S = 16;
    localparam int T = 4;
    localparam int D = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    source_sequencer_if bus();

    source_sequencer #(.DWELL_CYCLES(D), .SETTLE_CYCLES(S), .TRIG_WIDTH(T)) dut (
        .clk1280     (clk),
        .FPGA_RESETn (rst_n),
        .bus         (bus.slave)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model: time-stamps instead of states; a channel "settle window" starts at m_t0.
    int m_sel, m_t0, m_dref, cyc;
    bit m_auto, m_locked, m_pn, m_pm, chk_en;
    bit v_e, tr_e, ne, me, ex;
    int ds;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        if (obs !== exp_v) begin
            miscompares++;
            $display("FAIL %s cycle %0d: observed %0d expected %0d", tag, cyc, obs, exp_v);
        end
    endtask

    function automatic int m_next(input int sel, input logic [3:0] mask);
        for (int i = 1; i <= 4; i++) if (mask[(sel + i) % 4]) return (sel + i) % 4;
        return sel;
    endfunction

    function automatic bit m_expiring();
        int d0;
        d0 = (m_t0 + S > m_dref) ? m_t0 + S : m_dref;
        return m_locked && m_auto && cyc >= m_t0 + S && (cyc - d0 + 1 == D);
    endfunction

    task automatic model_reset();
        m_sel = 0; m_t0 = 0; m_dref = 0; cyc = 0;
        m_auto = 0; m_locked = 0; m_pn = 1; m_pm = 1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            v_e  = m_locked && cyc >= m_t0 + S;
            tr_e = v_e && cyc < m_t0 + S + T;
            check("sel", 32'(bus.sel), m_sel);
            check("src_valid", 32'(bus.src_valid), 32'(v_e));
            check("trigger", 32'(bus.trigger), 32'(tr_e));
            check("auto_mode", 32'(bus.auto_mode), 32'(m_auto));
            ne = m_pn && !bus.btn_next;
            me = m_pm && !bus.btn_mode;
            m_pn = bus.btn_next;
            m_pm = bus.btn_mode;
            ds = (m_t0 + S > m_dref) ? m_t0 + S : m_dref;
            ex = v_e && m_auto && !me && (cyc - ds + 1 == D);
            if (!bus.pll_locked) m_locked = 0;
            else if (!m_locked) begin
                m_locked = 1;
                m_t0 = cyc + 1;
            end else if (v_e) begin
                if (me || ex) m_dref = cyc + 1;
                if ((ne || ex) && bus.ch_mask != 0) begin
                    m_sel = m_next(m_sel, bus.ch_mask);
                    m_t0 = cyc + 1;
                end
            end
`ifdef SOURCE_SEQ_AUTO_EN
            if (me) m_auto = !m_auto;
`endif
            cyc++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_next();
        bus.btn_next = 1'b0; step(2);
        bus.btn_next = 1'b1; step(1);
    endtask

    task automatic press_mode();
        bus.btn_mode = 1'b0; step(2);
        bus.btn_mode = 1'b1; step(1);
    endtask

    task automatic reset_release();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        chk_en = 1'b1;
    endtask

    int s0;
    int k;

    initial begin
        chk_en = 1'b0;
        model_reset();
        bus.pll_locked = 1'b1;
        bus.btn_next = 1'b0;
        bus.btn_mode = 1'b1;
        bus.ch_mask = 4'b1111;
        step(3);
        check("rst_sel", 32'(bus.sel), 0);
        check("rst_valid", 32'(bus.src_valid), 0);
        check("rst_trig", 32'(bus.trigger), 0);
        check("rst_auto", 32'(bus.auto_mode), 0);
        reset_release();
        step(2);
        bus.btn_next = 1'b1;
        step(28);
        check("lock_valid", 32'(bus.src_valid), 1);

        press_next();
        step(25);
        check("manual_sel", 32'(bus.sel), 1);
        bus.ch_mask = 4'b1010;
        press_next();
        step(25);
        check("mask_skip_sel", 32'(bus.sel), 3);

        bus.ch_mask = 4'b0000;
        s0 = m_sel;
        press_next();
        check("mask0_valid", 32'(bus.src_valid), 1);
        check("mask0_sel", 32'(bus.sel), s0);
        bus.ch_mask = 4'(1 << m_sel);
        press_next();
        step(25);

        step(3);
        bus.pll_locked = 1'b0; step(5);
        bus.pll_locked = 1'b1; step(25);
        check("relock_sel", 32'(bus.sel), s0);

`ifdef SOURCE_SEQ_AUTO_EN
        bus.ch_mask = 4'b1010;
        press_mode();
        check("auto_on", 32'(bus.auto_mode), 1);
        step(100);
        bus.ch_mask = 4'b1111;
        step(30);
        for (k = 0; k < 200 && !m_expiring(); k++) step(1);
        if (!m_expiring()) check("dwell_timeout", 0, 1);
        s0 = m_sel;
        press_next();
        check("single_adv", 32'(bus.sel), (s0 + 1) % 4);
        step(30);
`else
        press_mode();
        step(3);
        check("auto_stays0", 32'(bus.auto_mode), 0);
`endif

        for (int i = 0; i < 3000; i++) begin
            k = $urandom_range(0, 99);
            if (k < 8) bus.btn_next = ~bus.btn_next;
            else if (k < 11 && bus.pll_locked) bus.btn_mode = ~bus.btn_mode;
            else if (k == 11) bus.pll_locked = 1'b0;
            else if (k < 14) bus.ch_mask = 4'($urandom_range(0, 15));
            else if (k > 60) bus.pll_locked = 1'b1;
            step(1);
        end

        bus.pll_locked = 1'b1;
        bus.btn_next = 1'b1;
        bus.btn_mode = 1'b1;
        bus.ch_mask = 4'b1111;
        step(40);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        chk_en = 1'b0;
        #1;
        check("async_sel", 32'(bus.sel), 0);
        check("async_valid", 32'(bus.src_valid), 0);
        check("async_trig", 32'(bus.trigger), 0);
        check("async_auto", 32'(bus.auto_mode), 0);
        step(2);
        reset_release();
        step(30);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
